// File: rtl/secuenciador_operandos.sv
`default_nettype none
// ============================================================================
// Module   : secuenciador_operandos
// Brief    : Operand fetch sequencer. Walks the operand ROM fetching (A, B)
//            pairs and hands each pair to the ALU over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module secuenciador_operandos #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] count_i,
    output logic [ADDR_W-1:0] addr_o,
    input  logic [DATA_W-1:0] operador_i,
    output logic [DATA_W-1:0] op_a_o,
    output logic [DATA_W-1:0] op_b_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH_A = 2'd1,
        FETCH_B = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pointer;
    logic [ADDR_W-1:0] pointer_next;
    logic [ADDR_W-1:0] remaining;
    logic [ADDR_W-1:0] remaining_next;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_a_next;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] op_b_next;
    logic              valid;
    logic              valid_next;
    logic              done;
    logic              done_next;
    logic              accept;

    // valid is registered, so a pair is only accepted while in PRESENT.
    assign accept = valid && ready_i;

    always_comb begin
        state_next     = state;
        pointer_next   = pointer;
        remaining_next = remaining;
        op_a_next      = op_a;
        op_b_next      = op_b;
        done_next      = 1'b0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    pointer_next   = base_addr_i;
                    remaining_next = count_i;
                    state_next     = FETCH_A;
                end
            end
            FETCH_A: begin
                op_a_next    = operador_i;
                pointer_next = pointer + ADDR_W'(1);
                state_next   = FETCH_B;
            end
            FETCH_B: begin
                op_b_next    = operador_i;
                pointer_next = pointer + ADDR_W'(1);
                state_next   = PRESENT;
            end
            PRESENT: begin
                if (accept) begin
                    if (remaining == '0) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        remaining_next = remaining - ADDR_W'(1);
                        state_next     = FETCH_A;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        valid_next = (state_next == PRESENT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            pointer   <= '0;
            remaining <= '0;
            op_a      <= '0;
            op_b      <= '0;
            valid     <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            pointer   <= pointer_next;
            remaining <= remaining_next;
            op_a      <= op_a_next;
            op_b      <= op_b_next;
            valid     <= valid_next;
            done      <= done_next;
        end
    end

    assign addr_o  = pointer;
    assign op_a_o  = op_a;
    assign op_b_o  = op_b;
    assign valid_o = valid;
    assign done_o  = done;
    assign busy_o  = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_secuenciador_operandos.sv
`default_nettype none
// Directed testbench for secuenciador_operandos; ROM word k = 0x1000_0000 + k.
module tb_secuenciador_operandos;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    logic              clk_i;
    logic              rst_i;
    logic              start_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [ADDR_W-1:0] count_i;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] operador_i;
    logic [DATA_W-1:0] op_a_o;
    logic [DATA_W-1:0] op_b_o;
    logic              valid_o;
    logic              ready_i;
    logic              busy_o;
    logic              done_o;

    int vectors;
    int errors;

    secuenciador_operandos #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .count_i     (count_i),
        .addr_o      (addr_o),
        .operador_i  (operador_i),
        .op_a_o      (op_a_o),
        .op_b_o      (op_b_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    assign operador_i = 32'h1000_0000 + {29'd0, addr_o};

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Runs until done_o or budget expiry, recording the first two accepted pairs.
    task automatic collect(input int budget, output int hs, output int dn,
                           output logic [31:0] a0, output logic [31:0] b0,
                           output logic [31:0] a1, output logic [31:0] b1,
                           output bit timeout);
        hs = 0; dn = 0; a0 = '0; b0 = '0; a1 = '0; b1 = '0; timeout = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (valid_o && ready_i) begin
                if (hs == 0) begin a0 = op_a_o; b0 = op_b_o; end
                if (hs == 1) begin a1 = op_a_o; b1 = op_b_o; end
                hs++;
            end
            tick();
            if (done_o) begin
                dn++;
                timeout = 1'b0;
                tick();
                if (done_o) dn++;
                break;
            end
        end
    endtask

    task automatic do_start(input logic [2:0] base, input logic [2:0] cnt);
        start_i = 1'b1; base_addr_i = base; count_i = cnt;
        tick();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; ready_i = 1'b0; base_addr_i = '0; count_i = '0;
        tick(); tick();
        rst_i = 1'b0;
        vectors++;
        if ({addr_o, valid_o, busy_o, done_o} !== 6'b000_000 ||
            op_a_o !== 32'd0 || op_b_o !== 32'd0) begin
            errors++;
            $display("FAIL reset: addr=%0d valid=%b busy=%b done=%b a=%h b=%h, required all zero",
                     addr_o, valid_o, busy_o, done_o, op_a_o, op_b_o);
        end
    endtask

    task automatic test_single();
        ready_i = 1'b1;
        do_start(3'd0, 3'd0);
        vectors++;
        if (addr_o !== 3'd0 || busy_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_fetch_a: addr=%0d busy=%b valid=%b, required 0 1 0", addr_o, busy_o, valid_o);
        end
        tick();
        vectors++;
        if (addr_o !== 3'd1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_fetch_b: addr=%0d valid=%b, required 1 0", addr_o, valid_o);
        end
        tick();
        vectors++;
        if (valid_o !== 1'b1 || op_a_o !== 32'h1000_0000 || op_b_o !== 32'h1000_0001) begin
            errors++;
            $display("FAIL single_pair: valid=%b a=%h b=%h, required 1 10000000 10000001", valid_o, op_a_o, op_b_o);
        end
        tick();
        vectors++;
        if (done_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_done: done=%b valid=%b, required 1 0", done_o, valid_o);
        end
        tick();
        vectors++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: done=%b busy=%b, required 0 0", done_o, busy_o);
        end
    endtask

    task automatic test_wrap();
        int hs, dn; logic [31:0] a0, b0, a1, b1; bit to;
        ready_i = 1'b1;
        do_start(3'd6, 3'd1);
        collect(40, hs, dn, a0, b0, a1, b1, to);
        vectors++;
        if (to || hs != 2 || dn != 1) begin
            errors++;
            $display("FAIL wrap_counts: timeout=%0d handshakes=%0d dones=%0d, required 0 2 1", to, hs, dn);
        end
        vectors++;
        if (a0 !== 32'h1000_0006 || b0 !== 32'h1000_0007 ||
            a1 !== 32'h1000_0000 || b1 !== 32'h1000_0001) begin
            errors++;
            $display("FAIL wrap_pairs: got (%h,%h) (%h,%h), required (10000006,10000007) (10000000,10000001)",
                     a0, b0, a1, b1);
        end
    endtask

    task automatic test_stall();
        ready_i = 1'b0;
        do_start(3'd2, 3'd0);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (valid_o !== 1'b1 || op_a_o !== 32'h1000_0002 || op_b_o !== 32'h1000_0003 ||
                addr_o !== 3'd4 || done_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b a=%h b=%h addr=%0d done=%b, required 1 10000002 10000003 4 0",
                         i, valid_o, op_a_o, op_b_o, addr_o, done_o);
            end
            tick();
        end
        ready_i = 1'b1;
        vectors++;
        if (valid_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_valid_at_accept: valid=%b, required 1", valid_o);
        end
        tick();
        vectors++;
        if (done_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: done=%b valid=%b, required 1 0", done_o, valid_o);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        ready_i = 1'b1;
        do_start(3'd0, 3'd0);
        tick();
        start_i = 1'b1; base_addr_i = 3'd5; count_i = 3'd3;
        tick();
        start_i = 1'b0;
        vectors++;
        if (valid_o !== 1'b1 || op_a_o !== 32'h1000_0000 || op_b_o !== 32'h1000_0001 || addr_o !== 3'd2) begin
            errors++;
            $display("FAIL ignore_pair: valid=%b a=%h b=%h addr=%0d, required 1 10000000 10000001 2",
                     valid_o, op_a_o, op_b_o, addr_o);
        end
        tick();
        vectors++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL ignore_done: done=%b, required 1", done_o);
        end
        tick();
        vectors++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL ignore_idle: busy=%b, required 0", busy_o);
        end
    endtask

    task automatic test_reset_mid();
        int hs, dn; logic [31:0] a0, b0, a1, b1; bit to;
        ready_i = 1'b1;
        do_start(3'd0, 3'd3);
        for (int i = 0; i < 5; i++) tick();
        vectors++;
        if (valid_o !== 1'b1 || op_a_o !== 32'h1000_0002) begin
            errors++;
            $display("FAIL rstmid_second_pair: valid=%b a=%h, required 1 10000002", valid_o, op_a_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        vectors++;
        if (valid_o !== 1'b0 || addr_o !== 3'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state: valid=%b addr=%0d busy=%b done=%b, required 0 0 0 0",
                     valid_o, addr_o, busy_o, done_o);
        end
        tick();
        vectors++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_done: done=%b busy=%b, required 0 0", done_o, busy_o);
        end
        do_start(3'd4, 3'd0);
        collect(20, hs, dn, a0, b0, a1, b1, to);
        vectors++;
        if (to || hs != 1 || dn != 1 || a0 !== 32'h1000_0004 || b0 !== 32'h1000_0005) begin
            errors++;
            $display("FAIL rstmid_restart: timeout=%0d hs=%0d dones=%0d pair=(%h,%h), required 0 1 1 (10000004,10000005)",
                     to, hs, dn, a0, b0);
        end
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b1;
        do_start(3'd0, 3'd0);
        tick(); tick(); tick();
        vectors++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_done: done=%b, required 1", done_o);
        end
        do_start(3'd3, 3'd0);
        vectors++;
        if (busy_o !== 1'b1 || addr_o !== 3'd3 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b addr=%0d done=%b, required 1 3 0", busy_o, addr_o, done_o);
        end
        tick(); tick();
        vectors++;
        if (valid_o !== 1'b1 || op_a_o !== 32'h1000_0003 || op_b_o !== 32'h1000_0004) begin
            errors++;
            $display("FAIL b2b_pair: valid=%b a=%h b=%h, required 1 10000003 10000004", valid_o, op_a_o, op_b_o);
        end
        tick();
        vectors++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_done: done=%b, required 1", done_o);
        end
        tick();
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_single();
        test_wrap();
        test_stall();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/secuenciador_operandos.md
Name: secuenciador_operandos

Overview:
Operand fetch sequencer that sits between the operand ROM (combinational read, ADDR_W-bit address, DATA_W-bit word) and the ALU. On a start command it walks consecutive ROM addresses and fetches operand pairs (A then B). It presents each pair to the ALU under a valid/ready handshake. It repeats for a programmed number of pairs, then pulses done.

Parameters:
DATA_W, 32, width of ROM word and of each operand.
ADDR_W, 3, ROM address width; depth = 2**ADDR_W; also the width of the pair-count input.

Ports:
clk_i  input  1  clock; all state changes on the rising edge.
rst_i  input  1  synchronous reset, active-high.
start_i  input  1  start request; sampled only in IDLE.
base_addr_i  input  ADDR_W  first ROM address; sampled with start_i.
count_i  input  ADDR_W  number of pairs minus 1 (0 → 1 pair, 7 → 8 pairs); sampled with start_i.
addr_o  output  ADDR_W  address to the operand ROM; driven from a register.
operador_i  input  DATA_W  ROM read data; combinational function of addr_o.
op_a_o  output  DATA_W  operand A to the ALU.
op_b_o  output  DATA_W  operand B to the ALU.
valid_o  output  1  op_a_o/op_b_o hold a valid pair.
ready_i  input  1  ALU accepts the pair when valid_o && ready_i.
busy_o  output  1  high in every state except IDLE.
done_o  output  1  one-cycle pulse after the last pair is accepted.

Behaviour:
- States: IDLE, FETCH_A, FETCH_B, PRESENT.
- Reset values: state IDLE, pointer 0 (addr_o=0), remaining-pair counter 0, op_a_o=0, op_b_o=0, valid_o=0, busy_o=0, done_o=0.
- Reset has priority over all other inputs. Reset asserted mid-operation:
  - forces IDLE on that edge;
  - valid_o drops the next cycle;
  - any pair in flight is discarded;
  - done_o is not pulsed.
- IDLE:
  - start_i=1 → pointer←base_addr_i, remaining←count_i, go to FETCH_A.
  - start_i=0 → stay; addr_o holds its last value.
- FETCH_A:
  - addr_o = pointer. At the edge: op_a_o←operador_i, pointer←pointer+1, go to FETCH_B.
- FETCH_B:
  - At the edge: op_b_o←operador_i, pointer←pointer+1, go to PRESENT.
- PRESENT:
  - valid_o=1. op_a_o, op_b_o and addr_o stay stable while ready_i=0; stalling is unbounded.
  - On valid_o && ready_i with remaining=0 → done_o=1 the next cycle, go to IDLE.
  - On valid_o && ready_i with remaining>0 → remaining←remaining−1, go to FETCH_A.
- Pointer arithmetic is modulo 2**ADDR_W; address 7+1 wraps to 0 silently.
- Latency: start_i sampled at edge N → FETCH_A in cycle N+1, FETCH_B in N+2, valid_o high from N+3. With ready_i held high, pair throughput is 1 per 3 cycles.
- valid_o is registered and depends only on state. It is never high in IDLE, FETCH_A or FETCH_B.
- start_i asserted while busy_o=1 is ignored and has no side effects.
- start_i in the same cycle that done_o is high: the FSM is in IDLE, so a new sequence starts normally.
- op_a_o and op_b_o keep their last values after done_o; they are meaningful only while valid_o=1.
- Total pairs delivered per start = count_i+1. Each ROM word is read exactly once per sequence, except that words are reread when 2*(count_i+1) > 2**ADDR_W (wrap).

Test Plan:
- Bench ROM word k = 0x1000_0000+k. Reset, then start_i with base=0, count=0, ready_i=1 → addr_o 0 then 1; valid_o high 3 cycles after start; pair (0x10000000, 0x10000001); done_o pulses 1 cycle later; busy_o low afterwards.
- base=6, count=1, ready_i=1 → pairs (0x10000006, 0x10000007) then (0x10000000, 0x10000001) via wrap; exactly 2 handshakes; one done_o pulse.
- base=2, count=0, ready_i held low 5 cycles after valid_o rises → op_a_o=0x10000002 and op_b_o=0x10000003 stable, valid_o high throughout; accepted on the first ready_i=1; done_o the next cycle.
- start_i re-pulsed with base=5 while in FETCH_B of a base=0 run → ignored; delivered pair still (0x10000000, 0x10000001).
- rst_i asserted during PRESENT of the second pair of a count=3 run → next cycle IDLE, valid_o=0, addr_o=0, no done_o; a subsequent start with base=4, count=0 yields (0x10000004, 0x10000005).
- Back-to-back: start_i in the cycle done_o=1 → new sequence begins; valid_o again 3 cycles later.
